// File: rtl/pilot_insert_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : pilot_insert_stream_if
//  Purpose  : Valid/ready sample stream bundle (data, valid, ready).
//  Modports : master - drives data/valid, receives ready
//             slave  - receives data/valid, drives ready
//  Revision : 1.0 - initial release
// ============================================================================
interface pilot_insert_stream_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/pilot_insert_stream.sv
`default_nettype none
// ============================================================================
//  Module   : pilot_insert_stream
//  Purpose  : Inserts pilot samples from a table into a data stream, one pilot
//             before every pilot_interval data samples, framed to
//             frame_length output samples (pilots included).
//  Ports    : clk, rst_n            - clock, asynchronous active-low reset
//             s_if (slave)          - upstream samples (data/valid/ready)
//             m_if (master)         - downstream samples (data/valid/ready)
//             frame_length_i        - output samples per frame
//             pilot_interval_i      - data samples between pilots
//             pilot_values_i        - pilot table, entry k at [k*DATA_W +: DATA_W]
//             pilot_inserted_o      - current output is a pilot
//             frame_end_o           - current output is last of its frame
//             error_o               - configuration sampled in IDLE is invalid
//  Revision : 1.0 - initial release
// ============================================================================
module pilot_insert_stream #(
    parameter int DATA_W                = 32,
    parameter int CNT_W                 = 13,
    parameter int NUM_PILOTS            = 4,
    parameter int PILOT_RESET_PER_FRAME = 1
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    pilot_insert_stream_if.slave              s_if,
    pilot_insert_stream_if.master             m_if,
    input  wire logic [CNT_W-1:0]             frame_length_i,
    input  wire logic [CNT_W-1:0]             pilot_interval_i,
    input  wire logic [NUM_PILOTS*DATA_W-1:0] pilot_values_i,
    output logic                              pilot_inserted_o,
    output logic                              frame_end_o,
    output logic                              error_o
);
    localparam int             IDX_W    = (NUM_PILOTS > 1) ? $clog2(NUM_PILOTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PILOTS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PILOT = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              pilot_q, pilot_d;
    logic              last_q, last_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_frame_q, cnt_frame_d;
    logic [CNT_W-1:0]  cnt_data_q, cnt_data_d;
    logic [CNT_W-1:0]  frame_len_q, frame_len_d;
    logic [CNT_W-1:0]  interval_q, interval_d;
    logic [IDX_W-1:0]  pilot_idx_q, pilot_idx_d;

    logic              load_ok;
    logic              load_en;
    logic              cfg_ok;
    logic              in_xfer;
    logic              frame_last;
    logic              interval_last;
    logic [DATA_W-1:0] pilot_sel;

    // Output register may take a new sample when empty or being drained.
    assign load_ok       = !valid_q || m_if.ready;
    assign cfg_ok        = (frame_length_i >= CNT_W'(2)) && (pilot_interval_i != '0);
    assign in_xfer       = (state_q == ST_DATA) && load_ok && s_if.valid;
    assign frame_last    = (cnt_frame_q == frame_len_q - CNT_W'(1));
    assign interval_last = (cnt_data_q == interval_q - CNT_W'(1));

    assign s_if.ready       = (state_q == ST_DATA) && load_ok;
    assign m_if.data        = data_q;
    assign m_if.valid       = valid_q;
    assign pilot_inserted_o = pilot_q;
    assign frame_end_o      = last_q;
    assign error_o          = error_q;

    always_comb begin : p_pilot_sel
        pilot_sel = pilot_values_i[DATA_W-1:0];
        for (int k = 0; k < NUM_PILOTS; k++) begin
            if (pilot_idx_q == IDX_W'(k)) begin
                pilot_sel = pilot_values_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // The last sample of a frame always returns to IDLE, cutting short any
    // partially filled pilot interval.
    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_ok && s_if.valid && load_ok) begin
                    state_d = ST_PILOT;
                end
            end
            ST_PILOT: begin
                if (load_ok) begin
                    state_d = frame_last ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (in_xfer) begin
                    if (frame_last) begin
                        state_d = ST_IDLE;
                    end else if (interval_last) begin
                        state_d = ST_PILOT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath next values ----------------
    always_comb begin : p_outputs
        data_d      = data_q;
        valid_d     = valid_q;
        pilot_d     = pilot_q;
        last_d      = last_q;
        error_d     = error_q;
        cnt_frame_d = cnt_frame_q;
        cnt_data_d  = cnt_data_q;
        pilot_idx_d = pilot_idx_q;
        frame_len_d = frame_len_q;
        interval_d  = interval_q;
        load_en     = 1'b0;

        // Drained with nothing new to load: the output slot empties.
        if (load_ok) begin
            valid_d = 1'b0;
            pilot_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Configuration is captured only here and frozen for the frame.
                frame_len_d = frame_length_i;
                interval_d  = pilot_interval_i;
                error_d     = !cfg_ok;
            end
            ST_PILOT: begin
                if (load_ok) begin
                    load_en     = 1'b1;
                    data_d      = pilot_sel;
                    pilot_d     = 1'b1;
                    cnt_data_d  = '0;
                    pilot_idx_d = (pilot_idx_q == IDX_LAST) ? '0 : pilot_idx_q + IDX_W'(1);
                end
            end
            ST_DATA: begin
                if (in_xfer) begin
                    load_en    = 1'b1;
                    data_d     = s_if.data;
                    pilot_d    = 1'b0;
                    cnt_data_d = cnt_data_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (load_en) begin
            valid_d = 1'b1;
            last_d  = frame_last;
            if (frame_last) begin
                cnt_frame_d = '0;
                if (PILOT_RESET_PER_FRAME != 0) begin
                    pilot_idx_d = '0;
                end
            end else begin
                cnt_frame_d = cnt_frame_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_datapath_reg
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            pilot_q     <= 1'b0;
            last_q      <= 1'b0;
            error_q     <= 1'b0;
            cnt_frame_q <= '0;
            cnt_data_q  <= '0;
            pilot_idx_q <= '0;
            frame_len_q <= '0;
            interval_q  <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            pilot_q     <= pilot_d;
            last_q      <= last_d;
            error_q     <= error_d;
            cnt_frame_q <= cnt_frame_d;
            cnt_data_q  <= cnt_data_d;
            pilot_idx_q <= pilot_idx_d;
            frame_len_q <= frame_len_d;
            interval_q  <= interval_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pilot_insert_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pilot_insert_stream
//  Purpose  : Scoreboard bench for pilot_insert_stream. Two instances share
//             stimulus: A resets the pilot index per frame, B free-runs it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pilot_insert_stream;
    localparam int DW = 32;
    localparam int CW = 13;
    localparam int NP = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          pilot;
        logic          last;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [CW-1:0]    frame_length;
    logic [CW-1:0]    pilot_interval;
    logic [NP*DW-1:0] pilots;
    logic             pil_a, end_a, err_a;
    logic             pil_b, end_b, err_b;

    pilot_insert_stream_if #(.DATA_W(DW)) in_a  ();
    pilot_insert_stream_if #(.DATA_W(DW)) out_a ();
    pilot_insert_stream_if #(.DATA_W(DW)) in_b  ();
    pilot_insert_stream_if #(.DATA_W(DW)) out_b ();

    pilot_insert_stream #(.DATA_W(DW), .CNT_W(CW), .NUM_PILOTS(NP), .PILOT_RESET_PER_FRAME(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_if(in_a), .m_if(out_a),
        .frame_length_i(frame_length), .pilot_interval_i(pilot_interval), .pilot_values_i(pilots),
        .pilot_inserted_o(pil_a), .frame_end_o(end_a), .error_o(err_a));

    pilot_insert_stream #(.DATA_W(DW), .CNT_W(CW), .NUM_PILOTS(NP), .PILOT_RESET_PER_FRAME(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_if(in_b), .m_if(out_b),
        .frame_length_i(frame_length), .pilot_interval_i(pilot_interval), .pilot_values_i(pilots),
        .pilot_inserted_o(pil_b), .frame_end_o(end_b), .error_o(err_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   in_cnt    = 0;   // data samples accepted by the DUTs
    int   model_dcnt = 0;  // data samples already assigned to expected frames
    int   idx_a = 0;
    int   idx_b = 0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dval(input int n);
        return 32'hD000_0000 + DW'(n);
    endfunction

    function automatic logic [DW-1:0] pval(input int k);
        return 32'hA000_0000 + DW'(k);
    endfunction

    // Expected output sequence of one whole frame for both instances.
    task automatic push_frame(input int fl, input int pi);
        int since;
        exp_t ea, eb;
        since = pi;
        for (int pos = 0; pos < fl; pos++) begin
            if (since == pi) begin
                ea = '{data: pval(idx_a), pilot: 1'b1, last: (pos == fl - 1)};
                eb = '{data: pval(idx_b), pilot: 1'b1, last: (pos == fl - 1)};
                idx_a = (idx_a + 1) % NP;
                idx_b = (idx_b + 1) % NP;
                since = 0;
            end else begin
                ea = '{data: dval(model_dcnt), pilot: 1'b0, last: (pos == fl - 1)};
                eb = ea;
                model_dcnt++;
                since++;
            end
            qa.push_back(ea);
            qb.push_back(eb);
        end
        idx_a = 0;
    endtask

    task automatic drive_inputs(input bit rnd_valid, input bit rnd_ready);
        logic v;
        v = (in_cnt < model_dcnt) && (!rnd_valid || ($urandom_range(0, 3) != 0));
        in_a.valid = v;
        in_b.valid = v;
        in_a.data  = dval(in_cnt);
        in_b.data  = dval(in_cnt);
        out_a.ready = !rnd_ready || ($urandom_range(0, 2) != 0);
        out_b.ready = out_a.ready;
    endtask

    task automatic run_until_empty(input bit rnd_valid, input bit rnd_ready);
        int budget;
        budget = 3000;
        while ((qa.size() != 0 || qb.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            drive_inputs(rnd_valid, rnd_ready);
            budget--;
        end
        check_val("drain_a", 64'(qa.size()), 64'd0);
        check_val("drain_b", 64'(qb.size()), 64'd0);
        @(posedge clk); #1;
        in_a.valid = 1'b0; in_b.valid = 1'b0;
        out_a.ready = 1'b1; out_b.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: sampled on the falling edge, transfers happen on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_a.valid && out_a.ready) begin
                if (qa.size() == 0) begin
                    check_val("unexpected_a", {32'd0, out_a.data}, 64'd0);
                end else begin
                    e = qa.pop_front();
                    check_val("a_data",  64'(out_a.data), 64'(e.data));
                    check_val("a_pilot", 64'(pil_a), 64'(e.pilot));
                    check_val("a_last",  64'(end_a), 64'(e.last));
                end
            end
            if (out_b.valid && out_b.ready) begin
                if (qb.size() == 0) begin
                    check_val("unexpected_b", {32'd0, out_b.data}, 64'd0);
                end else begin
                    e = qb.pop_front();
                    check_val("b_data",  64'(out_b.data), 64'(e.data));
                    check_val("b_pilot", 64'(pil_b), 64'(e.pilot));
                    check_val("b_last",  64'(end_b), 64'(e.last));
                end
            end
            if (stall_prev) begin
                check_val("hold_valid", 64'(out_a.valid), 64'd1);
                check_val("hold_data", 64'(out_a.data), 64'(stall_data));
            end
            if (out_a.valid && !out_a.ready) begin
                check_val("stall_ready_out", 64'(in_a.ready), 64'd0);
            end
            stall_prev = out_a.valid && !out_a.ready;
            stall_data = out_a.data;
            if (in_a.valid && in_a.ready) in_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        rst_n = 1'b0;
        frame_length = CW'(5);
        pilot_interval = CW'(2);
        pilots = {pval(2), pval(1), pval(0)};
        in_a.valid = 1'b0; in_b.valid = 1'b0;
        in_a.data = '0; in_b.data = '0;
        out_a.ready = 1'b1; out_b.ready = 1'b1;
        #3;
        check_val("rst_valid", 64'(out_a.valid), 64'd0);
        check_val("rst_data",  64'(out_a.data), 64'd0);
        check_val("rst_ready", 64'(in_a.ready), 64'd0);
        check_val("rst_flags", {61'd0, pil_a, end_a, err_a}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic two frames, both pilot index policies.
        push_frame(5, 2);
        push_frame(5, 2);
        run_until_empty(1'b0, 1'b0);

        // Random back-pressure and input gaps, several frame shapes.
        frame_length = CW'(11); pilot_interval = CW'(3);
        for (int f = 0; f < 3; f++) push_frame(11, 3);
        run_until_empty(1'b1, 1'b1);
        frame_length = CW'(4); pilot_interval = CW'(5);
        push_frame(4, 5); push_frame(4, 5);
        run_until_empty(1'b1, 1'b1);
        frame_length = CW'(3); pilot_interval = CW'(1);
        push_frame(3, 1); push_frame(3, 1);
        run_until_empty(1'b1, 1'b0);

        // Invalid configurations hold the block in IDLE with error raised.
        frame_length = CW'(5); pilot_interval = CW'(0);
        in_a.valid = 1'b1; in_b.valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("err_pi0", 64'(err_a), 64'd1);
        check_val("err_pi0_valid", 64'(out_a.valid), 64'd0);
        check_val("err_pi0_ready", 64'(in_a.ready), 64'd0);
        @(posedge clk); #1;
        frame_length = CW'(1); pilot_interval = CW'(2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("err_fl1", 64'(err_b), 64'd1);
        @(posedge clk); #1;
        frame_length = CW'(6); pilot_interval = CW'(3);
        push_frame(6, 3);
        run_until_empty(1'b0, 1'b0);
        check_val("err_clear", 64'(err_a), 64'd0);

        // Reset in the middle of a frame.
        frame_length = CW'(8);
        push_frame(8, 3);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            drive_inputs(1'b0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(out_a.valid), 64'd0);
        check_val("mid_rst_data", 64'(out_a.data), 64'd0);
        check_val("mid_rst_ready", 64'(in_a.ready), 64'd0);
        check_val("mid_rst_flags", {61'd0, pil_a, end_a, err_a}, 64'd0);
        qa.delete(); qb.delete();
        idx_a = 0; idx_b = 0;
        model_dcnt = in_cnt;
        frame_length = CW'(5); pilot_interval = CW'(2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_frame(5, 2);
        run_until_empty(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
